// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector:
// legal pattern-length bounds, the default pattern and the state-width rule.
package seq_det_pkg;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;
  localparam logic [3:0] DEFAULT_PAT = 4'b1011;

  function automatic int state_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_next.sv
// Combinational KMP-style transition function, evaluated directly from the
// live pattern so a newly loaded pattern takes effect immediately.
module seq_det_next
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int SW    = state_width(PAT_W)
) (
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [SW-1:0]    state_i,
  input  logic             w_i,
  input  logic             overlap_i,
  output logic [SW-1:0]    next_state_o
);

  // Bit idx of the pattern in serial order (idx 0 = first bit = MSB).
  function automatic logic pat_bit(input logic [PAT_W-1:0] p, input int idx);
    logic [PAT_W-1:0] sh;
    sh = p >> (PAT_W - 1 - idx);
    return sh[0];
  endfunction

  // Longest pattern prefix that is a suffix of (prefix_k, w).
  always_comb begin : p_next
    int   keff;
    int   best;
    int   idx;
    logic ok;
    logic sbit;
    keff = 0;
    best = 0;
    idx  = 0;
    ok   = 1'b0;
    sbit = 1'b0;
    if ((int'(state_i) == PAT_W) && !overlap_i) begin
      keff = 0;
    end else begin
      keff = int'(state_i);
    end
    for (int j = 1; j <= PAT_W; j++) begin
      ok = 1'b1;
      if (j <= keff + 1) begin
        for (int i = 0; i < PAT_W; i++) begin
          if (i < j) begin
            idx  = keff + 1 - j + i;
            sbit = (idx == keff) ? w_i : pat_bit(pattern_i, idx);
            if (pat_bit(pattern_i, i) != sbit) begin
              ok = 1'b0;
            end else begin
              ok = ok;
            end
          end else begin
            ok = ok;
          end
        end
      end else begin
        ok = 1'b0;
      end
      if (ok) begin
        best = j;
      end else begin
        best = best;
      end
    end
    next_state_o = SW'(best);
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: loadable pattern register, match-progress state,
// saturating match counter and Moore match flag.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W     = 4,
  parameter int CNT_W     = 8,
  parameter int OVERLAP   = 1,
  parameter     RESET_PAT = DEFAULT_PAT,
  parameter int SW        = state_width(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_pat,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             w_valid,
  input  logic             w,
  output logic [SW-1:0]    state,
  output logic [SW-1:0]    next_state,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
    $error("seq_pattern_detector: PAT_W=%0d outside legal range", PAT_W);
  end
  if ($bits(RESET_PAT) != PAT_W) begin : g_bad_reset_pat
    $error("seq_pattern_detector: RESET_PAT width %0d differs from PAT_W=%0d",
           $bits(RESET_PAT), PAT_W);
  end

  localparam logic [PAT_W-1:0] RESET_PAT_V = PAT_W'(RESET_PAT);
  localparam logic [SW-1:0]    MATCH_ST    = SW'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  logic [PAT_W-1:0] pat_q,   pat_d;
  logic [SW-1:0]    state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             z_q,     z_d;
  logic             sat_q,   sat_d;
  logic [SW-1:0]    nxt_s;

  seq_det_next #(
    .PAT_W (PAT_W),
    .SW    (SW)
  ) u_next (
    .pattern_i    (pat_q),
    .state_i      (state_q),
    .w_i          (w),
    .overlap_i    (OVERLAP != 0),
    .next_state_o (nxt_s)
  );

  // Load beats consumption; z and cnt_sat are precomputed so they come straight from flops.
  always_comb begin
    pat_d   = pat_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load_pat) begin
      pat_d   = pat_in;
      state_d = '0;
      cnt_d   = '0;
    end else if (w_valid) begin
      state_d = nxt_s;
      if ((nxt_s == MATCH_ST) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
    z_d   = (state_d == MATCH_ST);
    sat_d = (cnt_d == CNT_MAX);
  end

  // Detector state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= RESET_PAT_V;
      state_q <= '0;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      sat_q   <= sat_d;
    end
  end

  assign state      = state_q;
  assign next_state = w_valid ? nxt_s : state_q;
  assign z          = z_q;
  assign match_cnt  = cnt_q;
  assign cnt_sat    = sat_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench: overlapping and non-overlapping 4-bit detectors driven from
// one vector table, plus a 2-bit detector with a 2-bit counter for saturation.
module tb_seq_pattern_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_ab, ld_ab, wv_ab, w_ab;
  logic [3:0] pat_ab;
  logic [2:0] a_state, a_next, b_state, b_next;
  logic       a_z, b_z, a_sat, b_sat;
  logic [7:0] a_cnt, b_cnt;

  logic       rst_c, ld_c, wv_c, w_c;
  logic [1:0] pat_c;
  logic [1:0] c_state, c_next, c_cnt;
  logic       c_z, c_sat;

  seq_pattern_detector #(.PAT_W(4), .CNT_W(8), .OVERLAP(1), .RESET_PAT(4'b1011)) dut_a (
    .clk(clk), .reset(rst_ab), .load_pat(ld_ab), .pat_in(pat_ab), .w_valid(wv_ab), .w(w_ab),
    .state(a_state), .next_state(a_next), .z(a_z), .match_cnt(a_cnt), .cnt_sat(a_sat));

  seq_pattern_detector #(.PAT_W(4), .CNT_W(8), .OVERLAP(0), .RESET_PAT(4'b1011)) dut_b (
    .clk(clk), .reset(rst_ab), .load_pat(ld_ab), .pat_in(pat_ab), .w_valid(wv_ab), .w(w_ab),
    .state(b_state), .next_state(b_next), .z(b_z), .match_cnt(b_cnt), .cnt_sat(b_sat));

  seq_pattern_detector #(.PAT_W(2), .CNT_W(2), .OVERLAP(1), .RESET_PAT(2'b11)) dut_c (
    .clk(clk), .reset(rst_c), .load_pat(ld_c), .pat_in(pat_c), .w_valid(wv_c), .w(w_c),
    .state(c_state), .next_state(c_next), .z(c_z), .match_cnt(c_cnt), .cnt_sat(c_sat));

  typedef struct {
    logic       rst;
    logic       ld;
    logic [3:0] pat;
    logic       wv;
    logic       w;
    int         a_st;
    int         a_cn;
    int         b_st;
    int         b_cn;
  } vec_t;

  localparam int NV = 33;
  vec_t vecs[NV];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic rst, input logic ld, input logic [3:0] pat,
                              input logic wv, input logic w,
                              input int ast, input int acn, input int bst, input int bcn);
    vec_t v;
    v.rst = rst; v.ld = ld; v.pat = pat; v.wv = wv; v.w = w;
    v.a_st = ast; v.a_cn = acn; v.b_st = bst; v.b_cn = bcn;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    rst_ab = 1'b1; ld_ab = 1'b0; pat_ab = 4'b0000; wv_ab = 1'b0; w_ab = 1'b0;
    rst_c  = 1'b1; ld_c  = 1'b0; pat_c  = 2'b00;   wv_c  = 1'b0; w_c  = 1'b0;

    //            rst   ld    pat      wv    w     A st,cnt  B st,cnt
    vecs[0]  = mk(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 0, 0, 0, 0);
    vecs[1]  = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1, 0, 1, 0);
    vecs[2]  = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2, 0, 2, 0);
    vecs[3]  = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 3, 0, 3, 0);
    vecs[4]  = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4, 1, 4, 1);
    vecs[5]  = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2, 1, 0, 1);
    vecs[6]  = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 3, 1, 1, 1);
    vecs[7]  = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4, 2, 1, 1);
    vecs[8]  = mk(1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 0, 0, 0, 0);
    vecs[9]  = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1, 0, 1, 0);
    vecs[10] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2, 0, 2, 0);
    vecs[11] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 3, 0, 3, 0);
    vecs[12] = mk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 3, 0, 3, 0);
    vecs[13] = mk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 3, 0, 3, 0);
    vecs[14] = mk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 3, 0, 3, 0);
    vecs[15] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4, 1, 4, 1);
    vecs[16] = mk(1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 0, 0, 0, 0);
    vecs[17] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1, 0, 1, 0);
    vecs[18] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 2, 0, 2, 0);
    vecs[19] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 3, 0, 3, 0);
    vecs[20] = mk(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 0, 0, 0, 0);
    vecs[21] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1, 0, 1, 0);
    vecs[22] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2, 0, 2, 0);
    vecs[23] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 3, 0, 3, 0);
    vecs[24] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4, 1, 4, 1);
    vecs[25] = mk(1'b0, 1'b1, 4'b0110, 1'b1, 1'b1, 0, 0, 0, 0);
    vecs[26] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1, 0, 1, 0);
    vecs[27] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 2, 0, 2, 0);
    vecs[28] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 3, 0, 3, 0);
    vecs[29] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4, 1, 4, 1);
    vecs[30] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 2, 1, 0, 1);
    vecs[31] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 3, 1, 0, 1);
    vecs[32] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4, 2, 1, 1);

    for (int n = 0; n < NV; n++) begin
      @(negedge clk);
      rst_ab = vecs[n].rst; ld_ab = vecs[n].ld; pat_ab = vecs[n].pat;
      wv_ab  = vecs[n].wv;  w_ab  = vecs[n].w;
      #1;
      if (!vecs[n].rst && !vecs[n].ld) begin
        chk($sformatf("v%0d a_next_state", n), int'(a_next), vecs[n].a_st);
        chk($sformatf("v%0d b_next_state", n), int'(b_next), vecs[n].b_st);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d a_state", n), int'(a_state), vecs[n].a_st);
      chk($sformatf("v%0d a_z", n),     int'(a_z),     (vecs[n].a_st == 4) ? 1 : 0);
      chk($sformatf("v%0d a_cnt", n),   int'(a_cnt),   vecs[n].a_cn);
      chk($sformatf("v%0d a_sat", n),   int'(a_sat),   0);
      chk($sformatf("v%0d b_state", n), int'(b_state), vecs[n].b_st);
      chk($sformatf("v%0d b_z", n),     int'(b_z),     (vecs[n].b_st == 4) ? 1 : 0);
      chk($sformatf("v%0d b_cnt", n),   int'(b_cnt),   vecs[n].b_cn);
    end
    @(negedge clk);
    rst_ab = 1'b0; ld_ab = 1'b0; wv_ab = 1'b0;

    // Counter saturation on the 2-bit detector (pattern 11, counter width 2).
    @(negedge clk);
    rst_c = 1'b1;
    @(posedge clk); #1;
    chk("c_reset_cnt", int'(c_cnt), 0);
    chk("c_reset_sat", int'(c_sat), 0);
    chk("c_reset_z",   int'(c_z),   0);
    @(negedge clk);
    rst_c = 1'b0; wv_c = 1'b1; w_c = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("c_bit%0d_state", i), int'(c_state), (i >= 2) ? 2 : 1);
      chk($sformatf("c_bit%0d_z", i),     int'(c_z),     (i >= 2) ? 1 : 0);
      chk($sformatf("c_bit%0d_cnt", i),   int'(c_cnt),   (i - 1 > 3) ? 3 : i - 1);
      chk($sformatf("c_bit%0d_sat", i),   int'(c_sat),   (i >= 4) ? 1 : 0);
    end
    @(negedge clk);
    ld_c = 1'b1; pat_c = 2'b11;
    @(posedge clk); #1;
    chk("c_load_cnt",   int'(c_cnt),   0);
    chk("c_load_sat",   int'(c_sat),   0);
    chk("c_load_state", int'(c_state), 0);
    @(negedge clk);
    ld_c = 1'b0; wv_c = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
